// File: rtl/round_robin_arbiter_with_2_requests.sv
// Two-requester round-robin arbiter: combinational one-hot grant, with priority on a
// conflict going to the requester that was not granted most recently.
module round_robin_arbiter_with_2_requests (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] requests,
  output logic [1:0] grants
);

  // Index of the requester that was granted most recently.
  logic r_last_grant;
  logic [1:0] w_grants;

  always_comb begin
    w_grants = 2'b00;
    unique case (requests)
      2'b01:   w_grants = 2'b01;
      2'b10:   w_grants = 2'b10;
      2'b11:   w_grants = r_last_grant ? 2'b01 : 2'b10;
      default: w_grants = 2'b00;
    endcase
  end

  assign grants = w_grants;

  // An idle cycle leaves the priority history untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_grants[0]) begin
      r_last_grant <= 1'b0;
    end else if (w_grants[1]) begin
      r_last_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_with_2_requests.sv
// Self-checking bench for the two-requester round-robin arbiter: directed scenarios plus
// randomized traffic compared against a served-history reference model.
module tb_round_robin_arbiter_with_2_requests;

  logic       clk;
  logic       rst;
  logic [1:0] requests;
  logic [1:0] grants;

  int n_tests;
  int n_fail;
  int mdl_last_served;

  round_robin_arbiter_with_2_requests dut (
    .clk      (clk),
    .rst      (rst),
    .requests (requests),
    .grants   (grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a lone requester wins; on a conflict the one not served last wins.
  function automatic logic [1:0] rr_expect(input logic [1:0] req, input int last_served);
    int winner;
    if (req == 2'b00) return 2'b00;
    if (req == 2'b11) winner = 1 - last_served;
    else winner = (req == 2'b10) ? 1 : 0;
    return 2'(1 << winner);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_last_served = 1;
    end else if (requests == 2'b01 || requests == 2'b10 || requests == 2'b11) begin
      mdl_last_served = (rr_expect(requests, mdl_last_served) == 2'b10) ? 1 : 0;
    end
  end

  // Apply requests mid-cycle and settle before the caller samples.
  task automatic drive(input logic [1:0] req);
    @(negedge clk);
    requests = req;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    requests = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    requests = 2'b00;
    #1;
    n_tests++;
    if (grants !== 2'b00) begin
      $display("FAIL reset_idle: grants=%b required=00", grants);
      n_fail++;
    end
    @(negedge clk);
    requests = 2'b11;
    #1;
    n_tests++;
    if (grants !== 2'b01) begin
      $display("FAIL reset_conflict: grants=%b required=01", grants);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    requests = 2'b00;
  endtask

  task automatic test_priority_after_reset();
    logic [1:0] exp_seq [3];
    exp_seq = '{2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11);
      n_tests++;
      if (grants !== exp_seq[i]) begin
        $display("FAIL prio_after_reset[%0d]: grants=%b required=%b", i, grants, exp_seq[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_lone_requesters();
    logic [1:0] req_seq [7];
    logic [1:0] exp_seq [7];
    req_seq = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(req_seq[i]);
      n_tests++;
      if (grants !== exp_seq[i]) begin
        $display("FAIL lone[%0d]: req=%b grants=%b required=%b", i, req_seq[i], grants,
                 exp_seq[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_idle_holds();
    logic [1:0] req_seq [4];
    logic [1:0] exp_seq [4];
    req_seq = '{2'b10, 2'b00, 2'b00, 2'b11};
    exp_seq = '{2'b10, 2'b00, 2'b00, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(req_seq[i]);
      n_tests++;
      if (grants !== exp_seq[i]) begin
        $display("FAIL idle_hold[%0d]: req=%b grants=%b required=%b", i, req_seq[i], grants,
                 exp_seq[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_directed_32();
    logic [31:0] req0, req1, g0, g1;
    logic [1:0]  exp;
    req0 = 32'h7A2D5B7E;
    req1 = 32'hC0FA8488;
    g0   = 32'h3A255B76;
    g1   = 32'hC0DA8488;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive({req1[i], req0[i]});
      exp = {g1[i], g0[i]};
      n_tests++;
      if (grants !== exp) begin
        $display("FAIL directed32[%0d]: grants=%b required=%b", i, grants, exp);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    drive(2'b11);
    drive(2'b01);
    n_tests++;
    if (grants !== 2'b01) begin
      $display("FAIL midrst_grant0: grants=%b required=01", grants);
      n_fail++;
    end
    do_reset();
    drive(2'b11);
    n_tests++;
    if (grants !== 2'b01) begin
      $display("FAIL midrst_conflict: grants=%b required=01", grants);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      req = 2'($urandom_range(3, 0));
      drive(req);
      exp = rr_expect(req, mdl_last_served);
      n_tests++;
      if (grants !== exp) begin
        $display("FAIL random[%0d]: req=%b grants=%b required=%b", i, req, grants, exp);
        n_fail++;
      end
      n_tests++;
      if (grants === 2'b11 || (grants & ~req) !== 2'b00) begin
        $display("FAIL invariant[%0d]: req=%b grants=%b required=legal one-hot", i, req,
                 grants);
        n_fail++;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    mdl_last_served = 1;
    rst = 1'b1;
    requests = 2'b00;
    test_reset();
    test_priority_after_reset();
    test_lone_requesters();
    test_idle_holds();
    test_directed_32();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
